// File: rtl/seq_serializer.sv
// Word-to-bit serializer: DEPTH-entry FIFO feeding a shift FSM, one bit per clock on bout, gapless between words.
// Latency: first bit on bout one edge after a push into an idle, empty block. Backpressure: din_ready = !full.
module seq_serializer #(
    parameter int   WIDTH    = 8,
    parameter int   DEPTH    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic                     msb_first,
    output logic                     bout,
    output logic                     bout_valid,
    output logic                     byte_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic              bout_q, bout_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              full, empty, push, pop;
    logic [WIDTH-1:0]  head;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = din_valid && !full;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        bout_d  = bout_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) pop = 1'b1;
                else        bout_d = IDLE_BIT;
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    bout_d  = dir_q ? shreg_q[WIDTH-1] : shreg_q[0];
                    shreg_d = dir_q ? (shreg_q << 1) : (shreg_q >> 1);
                    cnt_d   = cnt_q - CW'(1);
                end else if (!empty) begin
                    pop = 1'b1;
                end else begin
                    bout_d  = IDLE_BIT;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // shreg holds only the bits not yet on bout, pre-aligned for the chosen order
        if (pop) begin
            dir_d   = msb_first;
            bout_d  = msb_first ? head[WIDTH-1] : head[0];
            shreg_d = msb_first ? (head << 1) : (head >> 1);
            cnt_d   = CW'(WIDTH-1);
            state_d = SHIFT;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (!push && pop) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            bout_q   <= IDLE_BIT;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            bout_q   <= bout_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign din_ready  = !full;
    assign bout       = bout_q;
    assign bout_valid = (state_q == SHIFT);
    assign byte_done  = (state_q == SHIFT) && (cnt_q == '0);
    assign busy       = !empty || (state_q == SHIFT);
    assign level      = count_q;
endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: directed scenarios plus random traffic, all cycles checked against a queue-based model.
module tb_seq_serializer;
    localparam int   W  = 8;
    localparam int   D  = 4;
    localparam logic IB = 1'b0;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         din_valid, din_ready, msb_first;
    logic         bout, bout_valid, byte_done, busy;
    logic [2:0]   level;

    seq_serializer #(.WIDTH(W), .DEPTH(D), .IDLE_BIT(IB)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .msb_first(msb_first), .bout(bout), .bout_valid(bout_valid), .byte_done(byte_done),
        .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: words waiting, and the bit stream of the word on the wire (front = bit on bout)
    logic [W-1:0] fq[$];
    logic         bq[$];

    logic         last_acc;
    logic [63:0]  bits_col;
    int           vcount, dcount, rises, det_hits;
    logic [3:0]   det4;
    logic         prev_v;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        bits_col = '0; vcount = 0; dcount = 0; rises = 0; det_hits = 0; det4 = '0;
    endtask

    task automatic check_outputs();
        check_eq("bout",       {31'd0, bout},       {31'd0, (bq.size() > 0) ? bq[0] : IB});
        check_eq("bout_valid", {31'd0, bout_valid}, {31'd0, bq.size() > 0});
        check_eq("byte_done",  {31'd0, byte_done},  {31'd0, bq.size() == 1});
        check_eq("busy",       {31'd0, busy},       {31'd0, (bq.size() > 0) || (fq.size() > 0)});
        check_eq("level",      {29'd0, level},      fq.size());
        check_eq("din_ready",  {31'd0, din_ready},  {31'd0, fq.size() < D});
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic m);
        logic [W-1:0] w;
        logic         tmp;
        din_valid = v; din = d; msb_first = m;
        @(posedge clk);
        last_acc = v && (fq.size() < D);
        if (bq.size() <= 1 && fq.size() > 0) begin
            w = fq.pop_front();
            bq.delete();
            for (int i = 0; i < W; i++) bq.push_back(m ? w[W-1-i] : w[i]);
        end else if (bq.size() > 0) begin
            tmp = bq.pop_front();
        end
        if (last_acc) fq.push_back(d);
        #1;
        check_outputs();
        if (bout_valid) begin
            bits_col = {bits_col[62:0], bout};
            vcount++;
            det4 = {det4[2:0], bout};
            if (det4 == 4'b1001) det_hits++;
        end
        if (byte_done) dcount++;
        if (bout_valid && !prev_v) rises++;
        prev_v = bout_valid;
    endtask

    task automatic drain(input logic m);
        for (int i = 0; i < 80 && (busy || bout_valid); i++) step(1'b0, W'($urandom), m);
        check_eq("drain_done", {31'd0, busy || bout_valid}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fq.delete(); bq.delete();
        prev_v = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    int idx, drop_at, pl;
    logic saw_full;

    initial begin
        reset = 1'b0; din = '0; din_valid = 1'b0; msb_first = 1'b1; prev_v = 1'b0; last_acc = 1'b0;
        clear_mon();
        #2 do_reset();
        #1 check_outputs();

        // T1: 9A MSB-first
        clear_mon();
        step(1'b1, 8'h9A, 1'b1);
        check_eq("t1_no_bit_at_push", {31'd0, bout_valid}, 32'd0);
        repeat (9) step(1'b0, 8'h00, 1'b1);
        check_eq("t1_bits",  bits_col[31:0], 32'h9A);
        check_eq("t1_vcnt",  vcount, 8);
        check_eq("t1_done",  dcount, 1);
        check_eq("t1_det",   det_hits, 1);

        // T2: 09 LSB-first
        clear_mon();
        step(1'b1, 8'h09, 1'b0);
        repeat (8) step(1'b0, 8'h00, 1'b0);
        check_eq("t2_bits", bits_col[31:0], 32'h90);
        step(1'b0, 8'h00, 1'b0);
        check_eq("t2_idle", {29'd0, bout, bout_valid, busy}, {29'd0, IB, 2'b00});

        // T3/T4: stream 01..06, sixth word meets a full FIFO while a pop happens
        clear_mon();
        idx = 1; drop_at = -10; saw_full = 1'b0;
        for (int c = 0; c < 40 && idx <= 6; c++) begin
            pl = level;
            step(1'b1, W'(idx), 1'b1);
            if (last_acc) begin
                if (idx == 6) check_eq("t4_accept_next", c, drop_at + 1);
                idx++;
            end else if (idx == 6 && pl == 4 && level == 3) begin
                drop_at = c;
            end
            if (level == 4 && !din_ready) saw_full = 1'b1;
        end
        check_eq("t3_all_pushed", idx, 7);
        check_eq("t3_saw_full", {31'd0, saw_full}, 32'd1);
        drain(1'b1);
        check_eq("t3_contig_bits", vcount, 48);
        check_eq("t3_one_run", rises, 1);
        check_eq("t3_tail", bits_col[47:0], 48'h010203040506);

        // T5: async reset three bits into F0, with a second word queued
        step(1'b1, 8'hF0, 1'b1);
        step(1'b1, 8'h55, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        #3 reset = 1'b1;
        fq.delete(); bq.delete();
        #1;
        check_eq("t5_async", {27'd0, bout, bout_valid, byte_done, busy, din_ready}, {27'd0, IB, 4'b0001});
        check_eq("t5_level", {29'd0, level}, 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        prev_v = 1'b0;
        clear_mon();
        step(1'b1, 8'h9A, 1'b1);
        repeat (9) step(1'b0, 8'h00, 1'b1);
        check_eq("t5_bits", bits_col[31:0], 32'h9A);
        check_eq("t5_vcnt", vcount, 8);

        // T6: order flips while a word is in flight
        clear_mon();
        step(1'b1, 8'hB4, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hB4, 1'b0);
        drain(1'b0);
        check_eq("t6_bits", bits_col[31:0], 32'hB42D);

        // random traffic with random order selection
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 9) < 6), W'($urandom), 1'($urandom));
        drain(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
